booth_mul_arbiter: RTL
======================

# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one sequential Radix-8 Booth multiplier core among NREQ requesters. Accepts one operand pair at a time over a valid/ready handshake. Launches the core with a start pulse, waits for its done strobe (with a watchdog), and returns the signed 2*WIDTH product, tagged with the requester id, over a single valid/ready response channel. Sits between the requesting datapath units and the multiplier core.

## Interface
- WIDTH, 32: operand width; product is 2*WIDTH, signed two's complement.
- NREQ, 4: number of requesters, ≥2; IDW = $clog2(NREQ).
- TIMEOUT, 64: maximum WAIT cycles before an error response; ≥ core latency + 1.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; must also reset the multiplier core.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  one-hot accept; at most one bit high.
- req_a  in  NREQ*WIDTH  multiplicands; slice i = [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  multipliers; same slicing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  requester index of response.
- rsp_product  out  2*WIDTH  signed product.
- rsp_err  out  1  response produced by timeout.
- mul_start  out  1  one-cycle core launch.
- mul_a, mul_b  out  WIDTH  core operands; stable from ISSUE through WAIT.
- mul_done  in  1  core result strobe.
- mul_product  in  2*WIDTH  core result; sampled when mul_done=1.

## Operation
- FSM states are IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, pick winner g by round robin, searching upward from last_grant+1 mod NREQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - On that edge: latch a, b and id=g, set last_grant=g, go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: mul_start=1 for exactly one cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - mul_done=1: latch mul_product, set rsp_err=0, go to RESP.
  - Otherwise, once the counter reaches TIMEOUT: product=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_product and rsp_err held stable.
  - When rsp_ready=1: go to IDLE.
- Requesters hold req_valid and their operands until accepted; the arbiter does not check this.
- mul_done outside WAIT is ignored, as is rsp_ready while rsp_valid=0.
- The arbiter performs no arithmetic; the product width is 2*WIDTH exactly as returned by the core.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0. last_grant=NREQ-1, so requester 0 wins first.
- Reset mid-operation: abandon the operation with no response. A mul_done arriving after reset is ignored.

## Timing
- Cycle 0 is the accept edge.
- Cycle 1: mul_start=1.
- Core latency L: mul_done at cycle 1+L.
- Cycle 2+L: rsp_valid=1.
- With rsp_ready held high, throughput is one operation per L+3 cycles.
- Timeout path: rsp_valid at cycle 2+TIMEOUT.
- rsp_valid does not drop without rsp_ready.
- No new accept occurs in the RESP→IDLE cycle; the earliest next accept is the cycle after the response handshake.

## Structure
- Package booth_mul_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the IDW helper;
  - the default WIDTH constant.
- Sub-module rr_arbiter (NREQ): inputs are the request vector and last_grant; outputs are the one-hot grant and its index. It is purely combinational.
- The top-level FSM, operand/result registers and watchdog counter live in booth_mul_arbiter.

## Test plan
Bench setup: WIDTH=32, NREQ=4, TIMEOUT=64, core = Radix-8 Booth core, L=12.
- Single request from requester 2, a=5, b=3 -> req_ready=4'b0100 same cycle; mul_start next cycle with mul_a=5, mul_b=3; rsp_valid with rsp_id=2, rsp_product=15, rsp_err=0 at cycle 14.
- All four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0; spacing L+3 cycles.
- rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_product stable; req_ready stays 0.
- Boundary operands:
  - a=-2147483648, b=-2147483648 -> 0x4000_0000_0000_0000.
  - a=2147483647, b=-2147483648 -> 0xC000_0000_8000_0000.
  - a=0, b=-1 -> 0.
- Stub core never asserts mul_done -> rsp_valid at cycle 66 with rsp_err=1, rsp_product=0; next request then serviced normally.
- reset in WAIT, then a late mul_done -> all outputs 0 the next cycle, no response; next grant goes to requester 0.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared state type, id-width helper and default operand width
package booth_mul_pkg;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just above the last grant
module rr_arbiter
    import booth_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw(NREQ)
)(
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);
    // walk requesters from last+1 upward with wrap; first active one wins
    always_comb begin
        int j;
        logic w_found;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(i_last) + k) % NREQ;
            if (!w_found && i_req[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one sequential multiplier core among NREQ requesters
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = idw(NREQ)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_product
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               r_state, w_next;
    logic [IDW-1:0]       r_last, r_id, w_idx;
    logic [NREQ-1:0]      w_gnt;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_a, r_b, w_a, w_b;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_err, w_timeout, w_accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    assign w_a         = req_a[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b         = req_b[int'(w_idx)*WIDTH +: WIDTH];
    assign w_accept    = (r_state == IDLE) && |req_valid;
    assign w_timeout   = r_cnt == CW'(TIMEOUT - 1);
    assign mul_a       = r_a;
    assign mul_b       = r_b;
    assign rsp_id      = r_id;
    assign rsp_product = r_prod;
    assign rsp_err     = r_err;

    // state register
    always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;

    // next state: a done strobe wins over a simultaneous watchdog expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |req_valid ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (mul_done || w_timeout) ? RESP : WAIT;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // outputs decoded from state; grants are suppressed while reset is asserted
    always_comb begin
        req_ready = (r_state == IDLE && !reset) ? w_gnt : '0;
        mul_start = r_state == ISSUE;
        rsp_valid = r_state == RESP;
    end

    // operand capture, watchdog counter and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= IDW'(NREQ - 1);
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_prod <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_id   <= w_idx;
                r_last <= w_idx;
            end
            if (r_state == ISSUE)
                r_cnt <= '0;
            else if (r_state == WAIT)
                r_cnt <= r_cnt + CW'(1);
            if (r_state == WAIT && mul_done) begin
                r_prod <= mul_product;
                r_err  <= 1'b0;
            end else if (r_state == WAIT && w_timeout) begin
                r_prod <= '0;
                r_err  <= 1'b1;
            end
        end
    end
endmodule
